alu_op_sequencer: RTL and testbench

//  Initiator side of the 32-bit ALU interface (A, B, ALU_Ctl -> Output, Zero_Flag) in the Lab 3 datapath.

---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_ctl_decode.sv | 67 ++++++
 rtl/alu_op_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU op sequencer: ALU control codes,
// MIPS opcode/funct encodings, FSM state and operand-B source select.
package alu_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    SEL_REG  = 2'd0,
    SEL_SIGN = 2'd1,
    SEL_ZERO = 2'd2
  } imm_sel_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational Opcode/Funct decode to ALU control and operand-B source.
// ILLEGAL_TRAP_EN: flag unsupported encodings; otherwise they decode as add.
module alu_ctl_decode
  import alu_seq_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctl,
  output imm_sel_e   o_imm_sel,
  output logic       o_is_beq,
  output logic       o_is_bne,
  output logic       o_illegal
);

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  always_comb begin
    o_alu_ctl = ALU_ADD;
    o_imm_sel = SEL_REG;
    o_is_beq  = 1'b0;
    o_is_bne  = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_alu_ctl = ALU_ADD;
          FN_SUB:  o_alu_ctl = ALU_SUB;
          FN_AND:  o_alu_ctl = ALU_AND;
          FN_OR:   o_alu_ctl = ALU_OR;
          FN_NOR:  o_alu_ctl = ALU_NOR;
          FN_SLT:  o_alu_ctl = ALU_SLT;
          default: o_illegal = TRAP_EN;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: begin
        o_alu_ctl = ALU_ADD;
        o_imm_sel = SEL_SIGN;
      end
      OP_SLTI: begin
        o_alu_ctl = ALU_SLT;
        o_imm_sel = SEL_SIGN;
      end
      OP_ANDI: begin
        o_alu_ctl = ALU_AND;
        o_imm_sel = SEL_ZERO;
      end
      OP_ORI: begin
        o_alu_ctl = ALU_OR;
        o_imm_sel = SEL_ZERO;
      end
      OP_BEQ: begin
        o_alu_ctl = ALU_SUB;
        o_is_beq  = 1'b1;
      end
      OP_BNE: begin
        o_alu_ctl = ALU_SUB;
        o_is_bne  = 1'b1;
      end
      default: o_illegal = TRAP_EN;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one decoded instruction at a time to an external ALU, holds operands
// for SETTLE_CYCLES, then returns the sampled result. ILLEGAL_TRAP_EN enables traps.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Instr_Valid,
  output logic             Instr_Ready,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Rs_Data,
  input  logic [WIDTH-1:0] Rt_Data,
  input  logic [15:0]      Imm,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_Ctl,
  input  logic [WIDTH-1:0] ALU_Result,
  input  logic             ALU_Zero,
  output logic             Res_Valid,
  input  logic             Res_Ready,
  output logic [WIDTH-1:0] Result,
  output logic             Branch_Taken,
  output logic             Illegal
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  seq_state_e       r_state;
  logic [3:0]       r_cnt;
  logic             r_instr_ready;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_ctl;
  logic             r_is_beq;
  logic             r_is_bne;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_branch;
  logic             r_illegal;

  logic [3:0]       w_alu_ctl;
  imm_sel_e         w_imm_sel;
  logic             w_is_beq;
  logic             w_is_bne;
  logic             w_illegal;
  logic [WIDTH-1:0] w_opnd_b;

  alu_ctl_decode u_decode (
    .i_opcode  (Opcode),
    .i_funct   (Funct),
    .o_alu_ctl (w_alu_ctl),
    .o_imm_sel (w_imm_sel),
    .o_is_beq  (w_is_beq),
    .o_is_bne  (w_is_bne),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_opnd_b = Rt_Data;
    case (w_imm_sel)
      SEL_SIGN: w_opnd_b = {{(WIDTH-16){Imm[15]}}, Imm};
      SEL_ZERO: w_opnd_b = {{(WIDTH-16){1'b0}}, Imm};
      default:  w_opnd_b = Rt_Data;
    endcase
  end

  // Trapped encodings go straight to RESP and leave the ALU operands untouched.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_instr_ready <= 1'b1;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_ctl     <= ALU_AND;
      r_is_beq      <= 1'b0;
      r_is_bne      <= 1'b0;
      r_res_valid   <= 1'b0;
      r_result      <= '0;
      r_branch      <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Instr_Valid && r_instr_ready) begin
            r_instr_ready <= 1'b0;
            if (w_illegal) begin
              r_state     <= RESP;
              r_res_valid <= 1'b1;
              r_result    <= '0;
              r_branch    <= 1'b0;
              r_illegal   <= 1'b1;
            end else begin
              r_state   <= ISSUE;
              r_cnt     <= 4'd0;
              r_alu_a   <= Rs_Data;
              r_alu_b   <= w_opnd_b;
              r_alu_ctl <= w_alu_ctl;
              r_is_beq  <= w_is_beq;
              r_is_bne  <= w_is_bne;
              r_illegal <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (r_cnt == LAST_CNT) begin
            r_state     <= RESP;
            r_res_valid <= 1'b1;
            r_result    <= ALU_Result;
            r_branch    <= (r_is_beq & ALU_Zero) | (r_is_bne & ~ALU_Zero);
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RESP: begin
          if (Res_Ready) begin
            r_state       <= IDLE;
            r_res_valid   <= 1'b0;
            r_instr_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_res_valid   <= 1'b0;
          r_instr_ready <= 1'b1;
        end
      endcase
    end
  end

  assign Instr_Ready  = r_instr_ready;
  assign ALU_A        = r_alu_a;
  assign ALU_B        = r_alu_b;
  assign ALU_Ctl      = r_alu_ctl;
  assign Res_Valid    = r_res_valid;
  assign Result       = r_result;
  assign Branch_Taken = r_branch;
  assign Illegal      = r_illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Lockstep bench for two sequencers (SETTLE_CYCLES=1 and 4) sharing stimulus,
// each driving its own behavioural ALU; results checked against an ISA-level model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imm;
  logic        res_ready;

  logic        ir1, ir4, rv1, rv4, bt1, bt4, il1, il4;
  logic [31:0] a1, b1, a4, b4, ar1, ar4, res1, res4;
  logic [3:0]  ctl1, ctl4;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_a, last_b;
  logic [3:0]  last_ctl;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign ar1 = alu_fn(ctl1, a1, b1);
  assign ar4 = alu_fn(ctl4, a4, b4);

  alu_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(1)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .Instr_Valid(instr_valid), .Instr_Ready(ir1),
    .Opcode(opcode), .Funct(funct), .Rs_Data(rs_data), .Rt_Data(rt_data), .Imm(imm),
    .ALU_A(a1), .ALU_B(b1), .ALU_Ctl(ctl1), .ALU_Result(ar1), .ALU_Zero(ar1 == 32'd0),
    .Res_Valid(rv1), .Res_Ready(res_ready), .Result(res1), .Branch_Taken(bt1), .Illegal(il1)
  );

  alu_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(4)) dut4 (
    .Clk(clk), .Rst_n(rst_n), .Instr_Valid(instr_valid), .Instr_Ready(ir4),
    .Opcode(opcode), .Funct(funct), .Rs_Data(rs_data), .Rt_Data(rt_data), .Imm(imm),
    .ALU_A(a4), .ALU_B(b4), .ALU_Ctl(ctl4), .ALU_Result(ar4), .ALU_Zero(ar4 == 32'd0),
    .Res_Valid(rv4), .Res_Ready(res_ready), .Result(res4), .Branch_Taken(bt4), .Illegal(il4)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    logic        bad;
  } exp_t;

  // ISA-level meaning of each instruction, independent of the ALU control encoding.
  function automatic exp_t ref_model(logic [5:0] op, logic [5:0] fn, logic [31:0] rs,
                                     logic [31:0] rt, logic [15:0] im);
    exp_t e;
    logic [31:0] sx, zx;
    sx = {{16{im[15]}}, im};
    zx = {16'h0000, im};
    e.ctl = 4'b0010; e.b = rt; e.res = rs + rt; e.br = 1'b0; e.bad = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h20: ;
        6'h22: begin e.ctl = 4'b0110; e.res = rs - rt; end
        6'h24: begin e.ctl = 4'b0000; e.res = rs & rt; end
        6'h25: begin e.ctl = 4'b0001; e.res = rs | rt; end
        6'h27: begin e.ctl = 4'b1100; e.res = ~(rs | rt); end
        6'h2A: begin e.ctl = 4'b0111; e.res = {31'd0, $signed(rs) < $signed(rt)}; end
        default: e.bad = 1'b1;
      endcase
      6'h23, 6'h2B, 6'h08: begin e.b = sx; e.res = rs + sx; end
      6'h0A: begin e.ctl = 4'b0111; e.b = sx; e.res = {31'd0, $signed(rs) < $signed(sx)}; end
      6'h0C: begin e.ctl = 4'b0000; e.b = zx; e.res = rs & zx; end
      6'h0D: begin e.ctl = 4'b0001; e.b = zx; e.res = rs | zx; end
      6'h04: begin e.ctl = 4'b0110; e.res = rs - rt; e.br = (rs == rt); end
      6'h05: begin e.ctl = 4'b0110; e.res = rs - rt; e.br = (rs != rt); end
      default: e.bad = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check_reset_state();
    check_val("rst_ready", {30'd0, ir1, ir4}, 32'd3);
    check_val("rst_valid", {30'd0, rv1, rv4}, 32'd0);
    check_val("rst_a", a1 | a4, 32'd0);
    check_val("rst_b", b1 | b4, 32'd0);
    check_val("rst_ctl", {24'd0, ctl1, ctl4}, 32'd0);
    check_val("rst_result", res1 | res4, 32'd0);
    check_val("rst_flags", {28'd0, bt1, bt4, il1, il4}, 32'd0);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [15:0] im, input int hold);
    exp_t e;
    bit trap_it;
    int lat1, lat4, n;
    logic [31:0] exp_res;
    e = ref_model(op, fn, rs, rt, im);
    trap_it = TRAP && e.bad;
    n = 0;
    while (!(ir1 && ir4) && n < 50) begin tick(); n++; end
    check_val("ready_wait", {31'd0, ir1 & ir4}, 32'd1);
    opcode = op; funct = fn; rs_data = rs; rt_data = rt; imm = im;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    opcode = 6'($urandom); funct = 6'($urandom); rs_data = $urandom; rt_data = $urandom; imm = 16'($urandom);
    lat1 = 0; lat4 = 0; n = 1;
    while ((lat1 == 0 || lat4 == 0) && n <= 20) begin
      if (n == 1) check_val("busy", {31'd0, ir1 | ir4}, 32'd0);
      if (!trap_it && lat1 == 0) begin
        check_val("alu_a1", a1, rs); check_val("alu_b1", b1, e.b); check_val("alu_ctl1", {28'd0, ctl1}, {28'd0, e.ctl});
      end
      if (!trap_it && lat4 == 0) begin
        check_val("alu_a4", a4, rs); check_val("alu_b4", b4, e.b); check_val("alu_ctl4", {28'd0, ctl4}, {28'd0, e.ctl});
      end
      if (rv1 && lat1 == 0) lat1 = n;
      if (rv4 && lat4 == 0) lat4 = n;
      if (lat1 == 0 || lat4 == 0) begin tick(); n++; end
    end
    check_val("latency1", lat1, trap_it ? 32'd1 : 32'd2);
    check_val("latency4", lat4, trap_it ? 32'd1 : 32'd5);
    exp_res = trap_it ? 32'd0 : e.res;
    check_val("result1", res1, exp_res);
    check_val("result4", res4, exp_res);
    check_val("branch", {30'd0, bt1, bt4}, (!trap_it && e.br) ? 32'd3 : 32'd0);
    check_val("illegal", {30'd0, il1, il4}, trap_it ? 32'd3 : 32'd0);
    if (trap_it) begin
      check_val("trap_a", a1 ^ a4 ^ last_a, last_a);
      check_val("trap_b", b1 ^ b4 ^ last_b, last_b);
      check_val("trap_ctl", {24'd0, ctl1, ctl4}, {24'd0, last_ctl, last_ctl});
    end else begin
      last_a = rs; last_b = e.b; last_ctl = e.ctl;
    end
    for (int k = 0; k < hold; k++) begin
      tick();
      check_val("hold_valid", {30'd0, rv1, rv4}, 32'd3);
      check_val("hold_res1", res1, exp_res);
      check_val("hold_res4", res4, exp_res);
      check_val("hold_ready", {30'd0, ir1, ir4}, 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_val("post_valid", {30'd0, rv1, rv4}, 32'd0);
    check_val("post_ready", {30'd0, ir1, ir4}, 32'd3);
  endtask

  localparam logic [5:0] OP_TAB [10] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h05};
  localparam logic [5:0] FN_TAB [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};

  initial begin
    logic [5:0]  op, fn;
    logic [31:0] rs, rt;
    rst_n = 1'b0; instr_valid = 1'b0; res_ready = 1'b0;
    opcode = 6'd0; funct = 6'd0; rs_data = 32'd0; rt_data = 32'd0; imm = 16'd0;
    last_a = 32'd0; last_b = 32'd0; last_ctl = 4'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_reset_state();

    run_instr(6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 0);
    run_instr(6'h04, 6'h00, 32'h1234, 32'h1234, 16'h0000, 0);
    run_instr(6'h05, 6'h00, 32'h1234, 32'h1234, 16'h0000, 1);
    run_instr(6'h0C, 6'h00, 32'hFFFFFFFF, 32'd0, 16'h8001, 0);
    run_instr(6'h0A, 6'h00, 32'hFFFFFFFE, 32'd0, 16'hFFFF, 0);
    run_instr(6'h00, 6'h22, 32'd3, 32'd9, 16'h0000, 5);
    run_instr(6'h00, 6'h3F, 32'd11, 32'd22, 16'h0000, 2);
    run_instr(6'h3E, 6'h00, 32'd1, 32'd2, 16'h0000, 0);

    // Reset while the slow instance is still mid-ISSUE: nothing may come back.
    opcode = 6'h00; funct = 6'h20; rs_data = 32'hAAAA; rt_data = 32'h5555; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #2;
    check_reset_state();
    tick();
    rst_n = 1'b1;
    last_a = 32'd0; last_b = 32'd0; last_ctl = 4'd0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_val("no_resp_after_rst", {30'd0, rv1, rv4}, 32'd0);
    end
    check_reset_state();

    for (int t = 0; t < 40; t++) begin
      op = OP_TAB[$urandom_range(0, 9)];
      fn = FN_TAB[$urandom_range(0, 6)];
      rs = $urandom;
      rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
      run_instr(op, fn, rs, rt, 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
